// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, opcode-class decode, RAW scoreboard and stall.
// Optional feature macro: HAZARD_INTERLOCK_EN (countdown scoreboard plus stall to fetch).
module id_stage #(
  parameter int unsigned IW     = 16,
  parameter int unsigned AW     = 10,
  parameter int unsigned OPW    = 6,
  parameter int unsigned WB_LAT = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IW-1:0]     iFetchedInst,
  input  logic [AW-1:0]     iNew_pc,
  input  logic              iBr_taken,
  output logic              oStall,
  output logic              oValid,
  output logic [OPW-1:0]    oOpcode,
  output logic [IW-OPW-1:0] oOperand,
  output logic [AW-1:0]     oPc,
  output logic              oWrA,
  output logic              oWrB,
  output logic              oWrC,
  output logic              oMemRd,
  output logic              oMemWr,
  output logic              oBranch,
  output logic [AW-1:0]     oBrTarget
);

  // Opcode map of the instruction set; anything else decodes as a no-effect bubble.
  localparam logic [OPW-1:0] OpNop  = OPW'(8'h00);
  localparam logic [OPW-1:0] OpLdca = OPW'(8'h01);
  localparam logic [OPW-1:0] OpLdcb = OPW'(8'h02);
  localparam logic [OPW-1:0] OpLda  = OPW'(8'h03);
  localparam logic [OPW-1:0] OpLdb  = OPW'(8'h04);
  localparam logic [OPW-1:0] OpSta  = OPW'(8'h05);
  localparam logic [OPW-1:0] OpStb  = OPW'(8'h06);
  localparam logic [OPW-1:0] OpAdda = OPW'(8'h07);
  localparam logic [OPW-1:0] OpAddb = OPW'(8'h08);
  localparam logic [OPW-1:0] OpBacs = OPW'(8'h09);
  localparam logic [OPW-1:0] OpBacc = OPW'(8'h0A);

  localparam logic [IW-1:0] NopInst = {OpNop, {(IW-OPW){1'b0}}};

  logic [IW-1:0] inst_q, inst_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          vld_q, vld_d;

  logic [OPW-1:0]    opcode;
  logic [IW-OPW-1:0] operand;
  logic known, wr_a, wr_b, wr_c, mem_rd, mem_wr, branch;
  logic hazard, issue;

  assign opcode  = inst_q[IW-1:IW-OPW];
  assign operand = inst_q[IW-OPW-1:0];

  always_comb begin
    known  = 1'b1;
    wr_a   = 1'b0;
    wr_b   = 1'b0;
    wr_c   = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    branch = 1'b0;
    case (opcode)
      OpLdca: wr_a = 1'b1;
      OpLdcb: wr_b = 1'b1;
      OpLda: begin
        wr_a   = 1'b1;
        mem_rd = 1'b1;
      end
      OpLdb: begin
        wr_b   = 1'b1;
        mem_rd = 1'b1;
      end
      OpSta, OpStb: mem_wr = 1'b1;
      OpAdda: begin
        wr_a = 1'b1;
        wr_c = 1'b1;
      end
      OpAddb: begin
        wr_b = 1'b1;
        wr_c = 1'b1;
      end
      OpBacs, OpBacc: branch = 1'b1;
      default: known = 1'b0;
    endcase
  end

`ifdef HAZARD_INTERLOCK_EN
  localparam int unsigned CW = $clog2(WB_LAT + 1);

  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_c_q, cnt_c_d;
  logic rd_a, rd_b, rd_c;

  always_comb begin
    rd_a = 1'b0;
    rd_b = 1'b0;
    rd_c = 1'b0;
    case (opcode)
      OpSta:          rd_a = 1'b1;
      OpStb:          rd_b = 1'b1;
      OpAdda, OpAddb: begin
        rd_a = 1'b1;
        rd_b = 1'b1;
      end
      OpBacs, OpBacc: rd_c = 1'b1;
      default: ;
    endcase
  end

  assign hazard = vld_q & ((rd_a & (cnt_a_q != '0)) |
                           (rd_b & (cnt_b_q != '0)) |
                           (rd_c & (cnt_c_q != '0)));

  function automatic logic [CW-1:0] cnt_next(input logic load, input logic [CW-1:0] cnt);
    if (load) return CW'(WB_LAT);
    if (cnt != '0) return cnt - CW'(1);
    return cnt;
  endfunction

  // Issue ignores iBr_taken: an instruction issuing in the flush cycle is already in execute.
  always_comb begin
    cnt_a_d = cnt_next(issue & wr_a, cnt_a_q);
    cnt_b_d = cnt_next(issue & wr_b, cnt_b_q);
    cnt_c_d = cnt_next(issue & wr_c, cnt_c_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  assign issue  = vld_q & known & ~hazard;
  assign oStall = hazard & ~iBr_taken;

  always_comb begin
    inst_d = inst_q;
    pc_d   = pc_q;
    vld_d  = vld_q;
    if (iBr_taken) begin
      inst_d = NopInst;
      pc_d   = '0;
      vld_d  = 1'b0;
    end else if (!hazard) begin
      inst_d = iFetchedInst;
      pc_d   = iNew_pc;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q <= NopInst;
      pc_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      inst_q <= inst_d;
      pc_q   <= pc_d;
      vld_q  <= vld_d;
    end
  end

  assign oValid    = issue;
  assign oOpcode   = opcode;
  assign oOperand  = operand;
  assign oPc       = pc_q;
  assign oWrA      = issue & wr_a;
  assign oWrB      = issue & wr_b;
  assign oWrC      = issue & wr_c;
  assign oMemRd    = issue & mem_rd;
  assign oMemWr    = issue & mem_wr;
  assign oBranch   = issue & branch;
  assign oBrTarget = AW'(operand);

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; scenarios follow whichever HAZARD_INTERLOCK_EN build
// is compiled.
module tb_id_stage;

  localparam logic [5:0] NOP = 6'h00, LDCA = 6'h01, LDCB = 6'h02, LDA = 6'h03, LDB = 6'h04;
  localparam logic [5:0] STA = 6'h05, STB = 6'h06, ADDA = 6'h07, BACS = 6'h09, BACC = 6'h0A;
  localparam logic [5:0] UNK = 6'h3E;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetched_inst;
  logic [9:0]  new_pc;
  logic        br_taken;
  logic        stall, valid, wr_a, wr_b, wr_c, mem_rd, mem_wr, branch;
  logic [5:0]  opcode;
  logic [9:0]  operand, pc, br_target;
  logic [6:0]  strb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk         (clk),
    .reset       (reset),
    .iFetchedInst(fetched_inst),
    .iNew_pc     (new_pc),
    .iBr_taken   (br_taken),
    .oStall      (stall),
    .oValid      (valid),
    .oOpcode     (opcode),
    .oOperand    (operand),
    .oPc         (pc),
    .oWrA        (wr_a),
    .oWrB        (wr_b),
    .oWrC        (wr_c),
    .oMemRd      (mem_rd),
    .oMemWr      (mem_wr),
    .oBranch     (branch),
    .oBrTarget   (br_target)
  );

  // {valid, wrA, wrB, wrC, memRd, memWr, branch}
  assign strb = {valid, wr_a, wr_b, wr_c, mem_rd, mem_wr, branch};

  function automatic logic [15:0] mk(input logic [5:0] op, input logic [9:0] opd);
    return {op, opd};
  endfunction

  task automatic present(input logic [15:0] inst, input logic [9:0] p, input logic br);
    fetched_inst = inst;
    new_pc       = p;
    br_taken     = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    present(mk(NOP, 10'h0), 10'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    present(mk(LDCA, 10'h5), 10'h7, 1'b0);
    tick();
    tick();
    total++; if (strb !== 7'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=%b", strb, 7'b0);
    end
    total++; if (stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall got=%b exp=0", stall);
    end
    total++; if (opcode !== NOP) begin
      bad++; $display("FAIL reset_opcode got=%h exp=%h", opcode, NOP);
    end
    total++; if ({operand, pc, br_target} !== 30'h0) begin
      bad++; $display("FAIL reset_fields got=%h exp=0", {operand, pc, br_target});
    end
    reset = 1'b0;
  endtask

  task automatic test_decode_classes();
    logic [15:0] tbl_inst[9];
    logic [6:0]  tbl_strb[9];
    tbl_inst = '{mk(BACC, 10'h3FF), mk(STA, 10'h001), mk(STB, 10'h002), mk(LDA, 10'h010),
                 mk(LDB, 10'h020), mk(LDCB, 10'h033), mk(UNK, 10'h155), mk(NOP, 10'h0AA),
                 mk(LDCA, 10'h200)};
    tbl_strb = '{7'b1000001, 7'b1000010, 7'b1000010, 7'b1100100, 7'b1010100, 7'b1010000,
                 7'b0000000, 7'b0000000, 7'b1100000};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      present((i < 9) ? tbl_inst[i] : mk(NOP, 10'h0), 10'(i + 1), 1'b0);
      if (i > 0) begin
        total++; if (strb !== tbl_strb[i-1]) begin
          bad++; $display("FAIL decode_strobes[%0d] got=%b exp=%b", i - 1, strb, tbl_strb[i-1]);
        end
        total++; if ({opcode, operand} !== tbl_inst[i-1]) begin
          bad++; $display("FAIL decode_fields[%0d] got=%h exp=%h", i - 1, {opcode, operand},
                          tbl_inst[i-1]);
        end
        total++; if (pc !== 10'(i)) begin
          bad++; $display("FAIL decode_pc[%0d] got=%h exp=%h", i - 1, pc, 10'(i));
        end
        total++; if (br_target !== tbl_inst[i-1][9:0]) begin
          bad++; $display("FAIL decode_target[%0d] got=%h exp=%h", i - 1, br_target,
                          tbl_inst[i-1][9:0]);
        end
        total++; if (stall !== 1'b0) begin
          bad++; $display("FAIL decode_stall[%0d] got=%b exp=0", i - 1, stall);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    present(mk(LDCA, 10'h9), 10'h1, 1'b0);
    tick();
    present(mk(LDCB, 10'h3), 10'h2, 1'b1);
    total++; if (strb !== 7'b1100000 || stall !== 1'b0) begin
      bad++; $display("FAIL flush_issue got=%b/%b exp=1100000/0", strb, stall);
    end
    tick();
    present(mk(LDCB, 10'h4), 10'h3, 1'b0);
    total++; if (valid !== 1'b0 || opcode !== NOP) begin
      bad++; $display("FAIL flush_bubble got=%b/%h exp=0/%h", valid, opcode, NOP);
    end
    tick();
    present(mk(STA, 10'h7), 10'h4, 1'b0);
    total++; if (strb !== 7'b1010000 || operand !== 10'h4) begin
      bad++; $display("FAIL flush_resume got=%b/%h exp=1010000/004", strb, operand);
    end
    tick();
`ifdef HAZARD_INTERLOCK_EN
    total++; if (stall !== 1'b1) begin
      bad++; $display("FAIL flush_counted got=%b exp=1", stall);
    end
`else
    total++; if (strb !== 7'b1000010) begin
      bad++; $display("FAIL flush_sta got=%b exp=1000010", strb);
    end
`endif
  endtask

`ifdef HAZARD_INTERLOCK_EN
  task automatic test_raw_stall();
    int nstall;
    do_reset();
    present(mk(LDCA, 10'h5), 10'h1, 1'b0);
    tick();
    present(mk(STA, 10'h125), 10'h2, 1'b0);
    total++; if (strb !== 7'b1100000 || opcode !== LDCA || operand !== 10'h5 || pc !== 10'h1) begin
      bad++; $display("FAIL raw_producer got=%b/%h/%h/%h", strb, opcode, operand, pc);
    end
    tick();
    nstall = 0;
    for (int i = 0; i < 5; i++) begin
      present(mk(STA, 10'h125), 10'h2, 1'b0);
      if (stall === 1'b1) nstall++;
      total++; if (valid !== 1'b0 || opcode !== STA) begin
        bad++; $display("FAIL raw_bubble[%0d] got=%b/%h exp=0/%h", i, valid, opcode, STA);
      end
      tick();
    end
    total++; if (nstall != 5) begin
      bad++; $display("FAIL raw_stall_count got=%0d exp=5", nstall);
    end
    present(mk(NOP, 10'h0), 10'h3, 1'b0);
    total++; if (stall !== 1'b0 || strb !== 7'b1000010 || operand !== 10'h125) begin
      bad++; $display("FAIL raw_consumer got=%b/%b/%h exp=0/1000010/125", stall, strb, operand);
    end
    tick();
  endtask

  task automatic test_no_stall_padding();
    logic [15:0] prog[8];
    int nstall;
    prog = '{mk(LDCA, 10'h5), mk(LDCB, 10'h7), mk(NOP, 10'h0), mk(NOP, 10'h0), mk(NOP, 10'h0),
             mk(NOP, 10'h0), mk(NOP, 10'h0), mk(ADDA, 10'h0)};
    do_reset();
    nstall = 0;
    for (int i = 0; i < 8; i++) begin
      present(prog[i], 10'(i + 1), 1'b0);
      if (stall !== 1'b0) nstall++;
      tick();
    end
    present(mk(NOP, 10'h0), 10'h9, 1'b0);
    if (stall !== 1'b0) nstall++;
    total++; if (nstall != 0) begin
      bad++; $display("FAIL pad_stall_count got=%0d exp=0", nstall);
    end
    total++; if (strb !== 7'b1101000 || opcode !== ADDA) begin
      bad++; $display("FAIL pad_adda got=%b/%h exp=1101000/%h", strb, opcode, ADDA);
    end
    tick();
  endtask

  task automatic test_branch_stall();
    do_reset();
    present(mk(ADDA, 10'h0), 10'h1, 1'b0);
    tick();
    present(mk(BACS, 10'd50), 10'h2, 1'b0);
    total++; if (strb !== 7'b1101000) begin
      bad++; $display("FAIL br_adda got=%b exp=1101000", strb);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      present(mk(BACS, 10'd50), 10'h2, 1'b0);
      total++; if (stall !== 1'b1 || valid !== 1'b0 || opcode !== BACS) begin
        bad++; $display("FAIL br_stall[%0d] got=%b/%b/%h exp=1/0/%h", i, stall, valid, opcode, BACS);
      end
      tick();
    end
    present(mk(NOP, 10'h0), 10'h3, 1'b0);
    total++; if (stall !== 1'b0 || strb !== 7'b1000001 || br_target !== 10'd50) begin
      bad++; $display("FAIL br_issue got=%b/%b/%0d exp=0/1000001/50", stall, strb, br_target);
    end
    tick();
  endtask

  task automatic test_flush_stall();
    do_reset();
    present(mk(LDCA, 10'h5), 10'h1, 1'b0);
    tick();
    present(mk(STA, 10'h125), 10'h2, 1'b0);
    tick();
    present(mk(STA, 10'h125), 10'h2, 1'b0);
    total++; if (stall !== 1'b1) begin
      bad++; $display("FAIL fs_pre got=%b exp=1", stall);
    end
    tick();
    present(mk(STA, 10'h125), 10'h2, 1'b1);
    total++; if (stall !== 1'b0 || valid !== 1'b0) begin
      bad++; $display("FAIL fs_flush got=%b/%b exp=0/0", stall, valid);
    end
    tick();
    present(mk(STA, 10'h0AA), 10'h4, 1'b0);
    total++; if (stall !== 1'b0 || valid !== 1'b0 || opcode !== NOP) begin
      bad++; $display("FAIL fs_after got=%b/%b/%h exp=0/0/%h", stall, valid, opcode, NOP);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      present(mk(STA, 10'h0AA), 10'h4, 1'b0);
      total++; if (stall !== 1'b1) begin
        bad++; $display("FAIL fs_countdown[%0d] got=%b exp=1", i, stall);
      end
      tick();
    end
    present(mk(NOP, 10'h0), 10'h5, 1'b0);
    total++; if (stall !== 1'b0 || strb !== 7'b1000010 || operand !== 10'h0AA) begin
      bad++; $display("FAIL fs_issue got=%b/%b/%h exp=0/1000010/0aa", stall, strb, operand);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    present(mk(LDCA, 10'h5), 10'h1, 1'b0);
    tick();
    present(mk(STA, 10'h125), 10'h2, 1'b0);
    tick();
    present(mk(STA, 10'h125), 10'h2, 1'b0);
    total++; if (stall !== 1'b1) begin
      bad++; $display("FAIL rms_pre got=%b exp=1", stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    present(mk(STA, 10'h125), 10'h2, 1'b0);
    total++; if (stall !== 1'b0 || valid !== 1'b0 || opcode !== NOP) begin
      bad++; $display("FAIL rms_clear got=%b/%b/%h exp=0/0/%h", stall, valid, opcode, NOP);
    end
    tick();
    present(mk(NOP, 10'h0), 10'h3, 1'b0);
    total++; if (stall !== 1'b0 || strb !== 7'b1000010) begin
      bad++; $display("FAIL rms_issue got=%b/%b exp=0/1000010", stall, strb);
    end
    tick();
  endtask
`else
  task automatic test_back_to_back();
    do_reset();
    present(mk(LDCA, 10'h5), 10'h1, 1'b0);
    tick();
    present(mk(STA, 10'h125), 10'h2, 1'b0);
    total++; if (strb !== 7'b1100000 || stall !== 1'b0) begin
      bad++; $display("FAIL b2b_ldca got=%b/%b exp=1100000/0", strb, stall);
    end
    tick();
    present(mk(NOP, 10'h0), 10'h3, 1'b0);
    total++; if (strb !== 7'b1000010 || stall !== 1'b0 || operand !== 10'h125) begin
      bad++; $display("FAIL b2b_sta got=%b/%b/%h exp=1000010/0/125", strb, stall, operand);
    end
    tick();
  endtask
`endif

  initial begin
    reset        = 1'b1;
    fetched_inst = 16'h0;
    new_pc       = 10'h0;
    br_taken     = 1'b0;
    test_reset();
    test_decode_classes();
    test_flush();
`ifdef HAZARD_INTERLOCK_EN
    test_raw_stall();
    test_no_stall_padding();
    test_branch_stall();
    test_flush_stall();
    test_reset_mid_stall();
`else
    test_back_to_back();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
